gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Global-history (gshare) conditional-branch direction predictor for the pipelined core. It sits beside the fetch stage: fetch presents the current PC each cycle and receives a same-cycle taken/not-taken prediction plus the table index used. The index travels down the pipeline with the branch. When the branch resolves in execute, the branch handler returns that index with the actual outcome. The block then trains its 2-bit counters, shifts its global history, and keeps saturating accuracy statistics that the debug display reads.

## Interface
Parameters:
- DBITS, 32, PC width.
- GHR_BITS, 8, global history length; must be <= PHT_INDEX_BITS.
- PHT_INDEX_BITS, 8, log2 of pattern-history-table entries (default 256 entries).
- CTR_INIT, 2'b01, reset value of every 2-bit counter (weakly not-taken).
- STAT_BITS, 16, width of the statistics counters.

Ports:
- clk  in  1  processor clock (divided core clock); all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- lk_pc  in  DBITS  fetch PC to predict.
- lk_taken  out  1  prediction: MSB of the indexed counter; combinational from lk_pc and current state.
- lk_idx  out  PHT_INDEX_BITS  index used for lk_taken; fetch carries it with the branch.
- upd_valid  in  1  a conditional branch resolved this cycle.
- upd_idx  in  PHT_INDEX_BITS  index returned with the resolving branch.
- upd_taken  in  1  actual branch outcome.
- upd_mispredict  in  1  prediction was wrong; used only when upd_valid=1.
- clr_stats  in  1  synchronous clear of the statistics counters.
- ghr  out  GHR_BITS  current global history register.
- br_count  out  STAT_BITS  resolved branches, saturating.
- mis_count  out  STAT_BITS  mispredicted branches, saturating.

## Operation
- Index: lk_idx = lk_pc[PHT_INDEX_BITS+1:2] XOR {zero-extend(ghr)}. PC bits [1:0] are ignored.
- PHT: 2^PHT_INDEX_BITS two-bit saturating counters. lk_taken = pht[lk_idx][1].
- Training, on a clk edge with upd_valid=1:
  - If upd_taken=1, pht[upd_idx] becomes min(ctr+1, 3).
  - If upd_taken=0, pht[upd_idx] becomes max(ctr-1, 0).
- Counter states:
  - 00: strong not-taken.
  - 01: weak not-taken.
  - 10: weak taken.
  - 11: strong taken.
  - Transitions never wrap: 11+taken stays 11; 00+not-taken stays 00.
- History: on upd_valid=1, ghr <= {ghr[GHR_BITS-2:0], upd_taken}. The LSB holds the newest outcome. History is non-speculative; no recovery is needed.
- Statistics:
  - br_count increments on upd_valid.
  - mis_count increments on upd_valid & upd_mispredict.
  - Both hold at all-ones (2^STAT_BITS-1) instead of wrapping.
  - clr_stats=1 zeroes both counters on the next edge and has priority over increment in the same cycle.
  - clr_stats does not touch the PHT or ghr.
- upd_valid=0: PHT, ghr and stats hold. upd_idx, upd_taken and upd_mispredict are don't-care.

## Timing
- Lookup has zero latency: lk_taken and lk_idx settle combinationally within the cycle lk_pc is presented.
- Update latency is one cycle: training, ghr and stats are visible from the cycle after the upd_valid edge.
- Simultaneous lookup and update to the same index in one cycle: lookup returns the pre-update counter and uses the pre-update ghr. No bypass.
- Reset (reset_n=0, asynchronous):
  - Every PHT entry becomes CTR_INIT.
  - ghr, br_count and mis_count become 0.
  - Resulting outputs: lk_taken = CTR_INIT[1] (0 by default) and lk_idx = lk_pc[PHT_INDEX_BITS+1:2].
- Reset asserted mid-operation discards any in-flight update. The first edge after reset_n rises performs normal updates.
- Deassertion is expected synchronised externally; the block adds no synchronizer.

## Test plan
- Reset values: hold reset_n=0, set lk_pc=0x40, then release. Required response:
  - lk_idx=0x10 and lk_taken=0.
  - ghr=0x00, br_count=0, mis_count=0.
- Training to taken and saturation: with ghr=0, apply upd_valid, upd_idx=0x10, upd_taken=1 on 3 consecutive edges.
  - Counter goes 01→10→11→11.
  - lk_taken (lk_pc=0x40) reads 0, then 1, then 1.
  - ghr ends at 0x07; br_count=3.
  - Next, 2 not-taken updates take the counter 11→10→01, so lk_taken=0.
- History hashing: after ghr=0x05 (outcomes 1,0,1), lk_pc=0x40 gives lk_idx=0x15. With GHR_BITS=8 and 9 further taken updates, ghr=0xFF and the oldest bit is shifted out.
- Same-cycle lookup/update: set pht[0x10]=01, then drive lk_pc=0x40 and upd_valid, upd_idx=0x10, upd_taken=1 together.
  - lk_taken=0 during that cycle.
  - lk_taken=1 the following cycle (provided ghr still hashes to 0x10).
- Statistics saturation and clear (STAT_BITS=4): issue 17 updates with upd_mispredict=1.
  - br_count=mis_count=0xF.
  - Pulse clr_stats with upd_valid=1 in the same cycle: both counters read 0 next cycle.
  - ghr still shifts on that cycle.
- Asynchronous reset mid-update: drop reset_n between edges while upd_valid=1.
  - Outputs clear immediately, without waiting for an edge.
  - After release the PHT is all CTR_INIT and no training from the aborted cycle is visible.

Source files
------------

// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history conditional-branch direction predictor.
//
// Fetch presents lk_pc each cycle and gets a same-cycle prediction (lk_taken)
// plus the table index used (lk_idx). When the branch resolves, execute returns
// that index with the real outcome. The block then trains the indexed 2-bit
// counter, shifts the outcome into the global history, and bumps saturating
// branch/mispredict statistics.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   lk_pc                fetch PC to predict
//   lk_taken, lk_idx     prediction and the PHT index behind it (combinational)
//   upd_valid            a conditional branch resolved this cycle
//   upd_idx              index carried with the resolving branch
//   upd_taken            actual outcome
//   upd_mispredict       prediction was wrong (qualified by upd_valid)
//   clr_stats            synchronous clear of br_count/mis_count
//   ghr                  global history, LSB = newest outcome
//   br_count, mis_count  saturating statistics

// One 2-bit saturating counter of the pattern history table.
module gshare_ctr #(
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       upd_en,
  input  logic       upd_taken,
  output logic [1:0] ctr
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctr <= CTR_INIT;
    end else if (upd_en) begin
      if (upd_taken) begin
        if (ctr != 2'b11) ctr <= ctr + 2'b01;
      end else begin
        if (ctr != 2'b00) ctr <= ctr - 2'b01;
      end
    end
  end
endmodule

module gshare_predictor #(
  parameter int         DBITS          = 32,
  parameter int         GHR_BITS       = 8,
  parameter int         PHT_INDEX_BITS = 8,
  parameter logic [1:0] CTR_INIT       = 2'b01,
  parameter int         STAT_BITS      = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DBITS-1:0]          lk_pc,
  output logic                      lk_taken,
  output logic [PHT_INDEX_BITS-1:0] lk_idx,
  input  logic                      upd_valid,
  input  logic [PHT_INDEX_BITS-1:0] upd_idx,
  input  logic                      upd_taken,
  input  logic                      upd_mispredict,
  input  logic                      clr_stats,
  output logic [GHR_BITS-1:0]       ghr,
  output logic [STAT_BITS-1:0]      br_count,
  output logic [STAT_BITS-1:0]      mis_count
);
  localparam int ENTRIES = 1 << PHT_INDEX_BITS;

  logic [ENTRIES-1:0][1:0] pht;
  logic [ENTRIES-1:0]      hit;

  // Word-aligned PC hashed with history; shorter history is zero-extended.
  assign lk_idx   = lk_pc[PHT_INDEX_BITS+1:2] ^ PHT_INDEX_BITS'(ghr);
  // Reads current state only: a same-cycle update to this entry is not bypassed.
  assign lk_taken = pht[lk_idx][1];

  genvar i;
  generate
    for (i = 0; i < ENTRIES; i++) begin : g_pht
      assign hit[i] = upd_valid && (upd_idx == PHT_INDEX_BITS'(i));
      gshare_ctr #(.CTR_INIT(CTR_INIT)) u_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .upd_en   (hit[i]),
        .upd_taken(upd_taken),
        .ctr      (pht[i])
      );
    end
  endgenerate

  // History is trained with resolved outcomes only, so it never needs repair.
  generate
    if (GHR_BITS > 1) begin : g_ghr_wide
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       ghr <= '0;
        else if (upd_valid) ghr <= {ghr[GHR_BITS-2:0], upd_taken};
      end
    end else begin : g_ghr_one
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       ghr <= '0;
        else if (upd_valid) ghr <= upd_taken;
      end
    end
  endgenerate

  // Statistics: clear beats increment; both stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_count  <= '0;
      mis_count <= '0;
    end else if (clr_stats) begin
      br_count  <= '0;
      mis_count <= '0;
    end else if (upd_valid) begin
      if (br_count != '1)                     br_count  <= br_count + STAT_BITS'(1);
      if (upd_mispredict && mis_count != '1)  mis_count <= mis_count + STAT_BITS'(1);
    end
  end
endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        lk_taken;
  logic [7:0]  lk_idx;
  logic        upd_valid = 1'b0;
  logic [7:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic        clr_stats = 1'b0;
  logic [7:0]  ghr;
  logic [3:0]  br_count;
  logic [3:0]  mis_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       tk;
    logic [7:0] idx;
    logic [7:0] ghr;
    logic [3:0] br;
    logic [3:0] mis;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic [1:0] m_pht [256];
  logic [7:0] m_ghr;
  logic [3:0] m_br, m_mis;

  gshare_predictor #(.STAT_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .lk_pc(lk_pc), .lk_taken(lk_taken),
    .lk_idx(lk_idx), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .clr_stats(clr_stats), .ghr(ghr), .br_count(br_count),
    .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 256; k++) m_pht[k] = 2'b01;
    m_ghr = '0; m_br = '0; m_mis = '0;
  endtask

  // One clock edge: advance the model, push expectation, then pop and compare.
  task automatic cycle();
    exp_t e, g;
    int   c;
    @(posedge clk);
    if (upd_valid) begin
      c = int'(m_pht[upd_idx]);
      c = upd_taken ? ((c + 1 > 3) ? 3 : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
      m_pht[upd_idx] = c[1:0];
      m_ghr = {m_ghr[6:0], upd_taken};
    end
    if (clr_stats) begin
      m_br = '0; m_mis = '0;
    end else if (upd_valid) begin
      if (m_br != 4'hF) m_br = m_br + 4'd1;
      if (upd_mispredict && m_mis != 4'hF) m_mis = m_mis + 4'd1;
    end
    e.idx = lk_pc[9:2] ^ m_ghr;
    e.tk  = m_pht[e.idx][1];
    e.ghr = m_ghr; e.br = m_br; e.mis = m_mis;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    total++;
    if ({lk_taken, lk_idx, ghr, br_count, mis_count} !== g) begin
      bad++;
      $display("FAIL sb_cycle got tk=%b idx=%h ghr=%h br=%h mis=%h want tk=%b idx=%h ghr=%h br=%h mis=%h",
               lk_taken, lk_idx, ghr, br_count, mis_count, g.tk, g.idx, g.ghr, g.br, g.mis);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    lk_pc = 32'h40;
    model_reset();
    #12 reset_n = 1'b1;
    #1;
    total++; if (lk_idx !== 8'h10) begin bad++; $display("FAIL reset_idx got %h want 10", lk_idx); end
    total++; if (lk_taken !== 1'b0) begin bad++; $display("FAIL reset_tk got %b want 0", lk_taken); end
    total++; if (ghr !== 8'h00) begin bad++; $display("FAIL reset_ghr got %h want 00", ghr); end
    total++; if (br_count !== 4'h0) begin bad++; $display("FAIL reset_br got %h want 0", br_count); end
    total++; if (mis_count !== 4'h0) begin bad++; $display("FAIL reset_mis got %h want 0", mis_count); end
  endtask

  task automatic test_train();
    logic [7:0] pc_idx [5] = '{8'h11, 8'h13, 8'h17, 8'h1E, 8'h0C};
    logic       tk_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    lk_pc = 32'h40;
    @(negedge clk);
    total++; if (lk_taken !== 1'b0) begin bad++; $display("FAIL train_pre got %b want 0", lk_taken); end
    for (int k = 0; k < 5; k++) begin
      upd_valid = 1'b1; upd_idx = 8'h10; upd_taken = (k < 3);
      cycle();
      upd_valid = 1'b0;
      lk_pc = {22'b0, pc_idx[k], 2'b00};  // re-aim the lookup at entry 0x10
      #1;
      total++;
      if (lk_idx !== 8'h10 || lk_taken !== tk_exp[k]) begin
        bad++; $display("FAIL train_%0d got idx=%h tk=%b want idx=10 tk=%b", k, lk_idx, lk_taken, tk_exp[k]);
      end
      if (k == 2) begin
        total++; if (ghr !== 8'h07) begin bad++; $display("FAIL train_ghr got %h want 07", ghr); end
        total++; if (br_count !== 4'd3) begin bad++; $display("FAIL train_br got %h want 3", br_count); end
      end
    end
  endtask

  task automatic test_hash();
    logic seq [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    lk_pc = 32'h40;
    for (int k = 0; k < 8; k++) begin
      upd_valid = 1'b1; upd_idx = 8'h33; upd_taken = seq[k];
      cycle();
    end
    upd_valid = 1'b0;
    total++; if (ghr !== 8'h05) begin bad++; $display("FAIL hash_ghr got %h want 05", ghr); end
    total++; if (lk_idx !== 8'h15) begin bad++; $display("FAIL hash_idx got %h want 15", lk_idx); end
    for (int k = 0; k < 9; k++) begin
      upd_valid = 1'b1; upd_idx = 8'(k + 8'h60); upd_taken = 1'b1;
      cycle();
    end
    upd_valid = 1'b0;
    total++; if (ghr !== 8'hFF) begin bad++; $display("FAIL hash_ghr_full got %h want ff", ghr); end
    total++; if (lk_idx !== 8'hEF) begin bad++; $display("FAIL hash_idx_full got %h want ef", lk_idx); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    lk_pc = 32'h40;
    upd_valid = 1'b1; upd_idx = 8'h10; upd_taken = 1'b1;
    #1;
    total++;
    if (lk_taken !== 1'b0 || lk_idx !== 8'h10) begin
      bad++; $display("FAIL same_pre got idx=%h tk=%b want idx=10 tk=0", lk_idx, lk_taken);
    end
    cycle();
    upd_valid = 1'b0;
    lk_pc = 32'h44;  // ghr is now 01, so this still hashes to 0x10
    #1;
    total++;
    if (lk_taken !== 1'b1 || lk_idx !== 8'h10) begin
      bad++; $display("FAIL same_post got idx=%h tk=%b want idx=10 tk=1", lk_idx, lk_taken);
    end
  endtask

  task automatic test_stats();
    logic [7:0] g_exp;
    for (int k = 0; k < 17; k++) begin
      upd_valid = 1'b1; upd_mispredict = 1'b1;
      upd_idx = 8'($urandom_range(255)); upd_taken = 1'($urandom_range(1));
      cycle();
    end
    total++; if (br_count !== 4'hF) begin bad++; $display("FAIL stat_br_sat got %h want f", br_count); end
    total++; if (mis_count !== 4'hF) begin bad++; $display("FAIL stat_mis_sat got %h want f", mis_count); end
    g_exp = {m_ghr[6:0], 1'b1};
    clr_stats = 1'b1; upd_taken = 1'b1;
    cycle();
    clr_stats = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    total++; if (br_count !== 4'h0) begin bad++; $display("FAIL stat_br_clr got %h want 0", br_count); end
    total++; if (mis_count !== 4'h0) begin bad++; $display("FAIL stat_mis_clr got %h want 0", mis_count); end
    total++; if (ghr !== g_exp) begin bad++; $display("FAIL stat_ghr_clr got %h want %h", ghr, g_exp); end
  endtask

  task automatic test_async_reset();
    do_reset();
    upd_valid = 1'b1; upd_idx = 8'h20; upd_taken = 1'b1; upd_mispredict = 1'b1;
    cycle();  // pht[0x20] -> 10, ghr -> 01
    lk_pc = {22'b0, 8'h21, 2'b00};
    #1;
    total++; if (lk_taken !== 1'b1) begin bad++; $display("FAIL async_pre got %b want 1", lk_taken); end
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (ghr !== 8'h0 || br_count !== 4'h0 || mis_count !== 4'h0 || lk_taken !== 1'b0 || lk_idx !== 8'h21) begin
      bad++; $display("FAIL async_clear got ghr=%h br=%h mis=%h tk=%b idx=%h want 00 0 0 0 21",
                      ghr, br_count, mis_count, lk_taken, lk_idx);
    end
    @(posedge clk);
    #1 upd_valid = 1'b0; upd_mispredict = 1'b0;
    #2 reset_n = 1'b1;
    for (int k = 0; k < 256; k++) begin
      lk_pc = {22'b0, 8'(k), 2'b00};
      #1;
      total++;
      if (lk_taken !== 1'b0) begin bad++; $display("FAIL async_pht_%0d got %b want 0", k, lk_taken); end
    end
    // First edge after release trains normally.
    lk_pc = {22'b0, 8'h21, 2'b00};
    upd_valid = 1'b1; upd_idx = 8'h20; upd_taken = 1'b1;
    cycle();
    upd_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_train();
    test_hash();
    test_same_cycle();
    test_stats();
    test_async_reset();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
